// File: rtl/prince_cms_pkg.sv
// ---------------------------------------------------------------------------
// prince_cms_pkg
// Shared constants and types for the PRINCE CMS S-box compression register.
// A CMS S-box evaluation produces NUM_OUT_SH nibble shares. They are folded
// down to NUM_IN_SH shares by XOR-ing contiguous groups of shares.
// ---------------------------------------------------------------------------
package prince_cms_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int NUM_OUT_SH = 8;
    localparam int NUM_IN_SH  = 2;

    // Number of expanded shares that are folded into one output share
    localparam int SH_PER_OUT = NUM_OUT_SH / NUM_IN_SH;

    // Packed so that element k lines up with bits [4k+3:4k] of a flat word
    typedef logic [NUM_OUT_SH-1:0][NIBBLE_W-1:0] cms_shares_t;

    // XOR of shares lo..hi (inclusive); used to fold one group of shares
    function automatic logic [NIBBLE_W-1:0] xorShares(input cms_shares_t sh,
                                                      input int lo,
                                                      input int hi);
        logic [NIBBLE_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_OUT_SH; k++) begin
            if (k >= lo && k <= hi) begin
                acc = acc ^ sh[k];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/cms_ring_refresh.sv
// ---------------------------------------------------------------------------
// cms_ring_refresh
// Combinational ring refresh of the expanded shares. Every share k is masked
// with random nibbles k and (k+1) mod NUM_OUT_SH. Each random nibble is used
// exactly twice, so the XOR of all shares (the unmasked value) is unchanged.
//
// Ports
//   i_sh  : expanded shares before refresh
//   i_rnd : fresh randomness, one nibble per share
//   o_sh  : refreshed shares
// ---------------------------------------------------------------------------
module cms_ring_refresh
    import prince_cms_pkg::*;
(
    input  cms_shares_t                       i_sh,
    input  logic [NUM_OUT_SH*NIBBLE_W-1:0]    i_rnd,
    output cms_shares_t                       o_sh
);

    cms_shares_t w_rnd;

    assign w_rnd = i_rnd;

    // Ring mask: neighbouring shares share one random nibble, the last share
    // wraps around to share 0 so that the masks cancel in the total XOR.
    always_comb begin
        o_sh = i_sh;
        for (int k = 0; k < NUM_OUT_SH; k++) begin
            o_sh[k] = i_sh[k] ^ w_rnd[k] ^ w_rnd[(k + 1) % NUM_OUT_SH];
        end
    end

endmodule

// File: rtl/prince_sbox_cms_reg.sv
// ---------------------------------------------------------------------------
// prince_sbox_cms_reg
// Two-stage valid/ready register that compresses 8 CMS output shares of a
// PRINCE S-box into a 2-share nibble. Stage 1 stores the shares untouched
// (optionally ring-refreshed) so no cross-share XOR happens before a register.
// Stage 2 folds shares 0..3 into dout_sh0 and shares 4..7 into dout_sh1.
//
// Configuration macro: PRINCE_CMS_REFRESH_EN
//   defined   : stage-1 capture applies the ring refresh using rnd
//   undefined : rnd is ignored, shares are captured as they arrive
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : din_sh holds a complete expanded S-box result
//   in_ready   : block accepts din_sh this cycle
//   din_sh     : 8 shares x 4 bits, share k = bits [4k+3:4k]
//   rnd        : refresh randomness, sampled on accept
//   out_valid  : dout_sh0/dout_sh1 hold a valid nibble
//   out_ready  : downstream takes the output this cycle
//   dout_sh0/1 : compressed output shares
// ---------------------------------------------------------------------------
module prince_sbox_cms_reg
    import prince_cms_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_OUT_SH*NIBBLE_W-1:0]   din_sh,
    input  logic [NUM_OUT_SH*NIBBLE_W-1:0]   rnd,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NIBBLE_W-1:0]              dout_sh0,
    output logic [NIBBLE_W-1:0]              dout_sh1
);

    logic                r_s1Valid;
    cms_shares_t         r_s1Sh;
    logic                r_s2Valid;
    logic [NIBBLE_W-1:0] r_dout0;
    logic [NIBBLE_W-1:0] r_dout1;

    cms_shares_t         w_dinSh;
    cms_shares_t         w_capSh;
    logic                w_s2Free;
    logic                w_s1Adv;
    logic                w_accept;

    assign w_dinSh = din_sh;

`ifdef PRINCE_CMS_REFRESH_EN
    cms_ring_refresh u_refresh (
        .i_sh  (w_dinSh),
        .i_rnd (rnd),
        .o_sh  (w_capSh)
    );
`else
    // rnd stays on the port so both builds share one interface
    logic w_unused;
    assign w_unused = ^rnd;
    assign w_capSh  = w_dinSh;
`endif

    // Stage 2 can take new data when it is empty or is being drained this
    // cycle; stage 1 can then move forward, which frees it for a new accept.
    assign w_s2Free = ~r_s2Valid | out_ready;
    assign w_s1Adv  = r_s1Valid & w_s2Free;
    assign in_ready = ~r_s1Valid | w_s2Free;
    assign w_accept = in_valid & in_ready;

    // Stage 1: holds the raw (or refreshed) shares. It is refilled on the
    // same edge it hands its contents to stage 2, giving full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Sh    <= '0;
        end else begin
            if (w_accept) begin
                r_s1Sh <= w_capSh;
            end
            r_s1Valid <= w_accept | (r_s1Valid & ~w_s1Adv);
        end
    end

    // Stage 2: folds each half of the shares into one output share. When the
    // downstream stalls, nothing here changes so the output stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_dout0   <= '0;
            r_dout1   <= '0;
        end else if (w_s2Free) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_dout0 <= xorShares(r_s1Sh, 0, SH_PER_OUT - 1);
                r_dout1 <= xorShares(r_s1Sh, SH_PER_OUT, NUM_OUT_SH - 1);
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign dout_sh0  = r_dout0;
    assign dout_sh1  = r_dout1;

endmodule

// File: tb/tb_prince_sbox_cms_reg.sv
// ---------------------------------------------------------------------------
// tb_prince_sbox_cms_reg
// Directed and random stimulus for prince_sbox_cms_reg. A transaction-level
// model (a queue of in-flight results with their age) predicts in_ready,
// out_valid and the two output shares every cycle. Honours
// PRINCE_CMS_REFRESH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_prince_sbox_cms_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din_sh;
    logic [31:0] rnd;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  dout_sh0;
    logic [3:0]  dout_sh1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] u;
        int         age;
    } item_t;

    item_t q[$];
    int    accepted  = 0;
    int    delivered = 0;
    logic  expReady;
    logic  expValid;
    logic  hs;
    logic  acc;

    prince_sbox_cms_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_sh    (din_sh),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_sh0  (dout_sh0),
        .dout_sh1  (dout_sh1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected item from the abstract rules: the output shares are the XOR of
    // the lower and upper four input nibbles; with the ring refresh each half
    // additionally picks up rnd nibbles 0 and 4 (all others cancel).
    function automatic item_t makeItem(input logic [31:0] d, input logic [31:0] r);
        item_t it;
        it.e0  = d[3:0] ^ d[7:4] ^ d[11:8] ^ d[15:12];
        it.e1  = d[19:16] ^ d[23:20] ^ d[27:24] ^ d[31:28];
`ifdef PRINCE_CMS_REFRESH_EN
        it.e0  = it.e0 ^ r[3:0] ^ r[19:16];
        it.e1  = it.e1 ^ r[3:0] ^ r[19:16];
`else
        if (r == 32'h0) it.e0 = it.e0;
`endif
        it.u   = it.e0 ^ it.e1;
        it.age = 0;
        return it;
    endfunction

    // Model compare and update. Inputs change just after a rising edge, so at
    // the falling edge they already describe what the next rising edge does.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
            checkOutput("rst_dout", {24'b0, dout_sh0, dout_sh1}, 32'h0);
        end else begin
            expReady = (q.size() < 2) || out_ready;
            expValid = (q.size() > 0) && (q[0].age >= 1);
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expValid});
            if (expValid) begin
                checkOutput("dout_sh0", {28'b0, dout_sh0}, {28'b0, q[0].e0});
                checkOutput("dout_sh1", {28'b0, dout_sh1}, {28'b0, q[0].e1});
                checkOutput("unmasked", {28'b0, dout_sh0 ^ dout_sh1}, {28'b0, q[0].u});
            end
            hs  = expValid && out_ready;
            acc = in_valid && expReady;
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (hs) begin
                void'(q.pop_front());
                delivered++;
            end
            if (acc) begin
                q.push_back(makeItem(din_sh, rnd));
                accepted++;
            end
        end
    end

    // Drive one cycle of inputs and report whether the DUT accepted them
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic [31:0] r, input logic ordy,
                                 output logic accOut);
        @(posedge clk);
        #1;
        in_valid  = v;
        din_sh    = d;
        rnd       = r;
        out_ready = ordy;
        @(negedge clk);
        accOut = v && in_ready;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic        a;
    int          idx;
    int          cnt;
    int          firstV;
    int          lastV;
    int          d0;
    logic [31:0] vec[3];
    logic [3:0]  want29;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din_sh    = '0;
        rnd       = '0;
        resetDut();
        @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset_dout", {24'b0, dout_sh0, dout_sh1}, 32'h0);

        // Single nibble, latency of two cycles
        applyStimulus(1'b1, 32'h0000_000F, 32'h0, 1'b1, a);
        checkOutput("t28_accept", {31'b0, a}, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        checkOutput("t28_not_early", {31'b0, out_valid}, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        checkOutput("t28_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t28_dout_sh0", {28'b0, dout_sh0}, 32'hF);
        checkOutput("t28_dout_sh1", {28'b0, dout_sh1}, 32'h0);

        // Refresh vector: unmasked 8; split 3/B with refresh, C/4 without
`ifdef PRINCE_CMS_REFRESH_EN
        want29 = 4'h3;
`else
        want29 = 4'hC;
`endif
        applyStimulus(1'b1, 32'h1234_5678, 32'hA5A5_5A5A, 1'b1, a);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        checkOutput("t29_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t29_unmasked", {28'b0, dout_sh0 ^ dout_sh1}, 32'h8);
        checkOutput("t29_dout_sh0", {28'b0, dout_sh0}, {28'b0, want29});

        // Ten back-to-back nibbles, outputs must be on consecutive cycles
        cnt = 0; firstV = -1; lastV = -1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i < 10, 32'h9E37_79B9 * (i + 1), 32'h1357_9BDF + i, 1'b1, a);
            if (i < 10) checkOutput("t30_accept", {31'b0, a}, 32'h1);
            if (out_valid) begin
                cnt++;
                if (firstV < 0) firstV = i;
                lastV = i;
            end
        end
        checkOutput("t30_count", cnt, 32'd10);
        checkOutput("t30_contiguous", lastV - firstV + 1, 32'd10);

        // Backpressure: only two fit, output held, then both drain in order
        vec[0] = 32'hDEAD_BEEF; vec[1] = 32'h0F1E_2D3C; vec[2] = 32'h7777_0001;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(idx < 3, vec[idx % 3], 32'hCAFE_F00D, 1'b0, a);
            if (a) idx++;
        end
        checkOutput("t31_accepted", idx, 32'd2);
        checkOutput("t31_in_ready", {31'b0, in_ready}, 32'h0);
        d0 = delivered;
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        checkOutput("t31_delivered", delivered - d0, 32'd2);

        // Reset while both stages are full
        applyStimulus(1'b1, 32'h1111_2222, 32'h0, 1'b0, a);
        applyStimulus(1'b1, 32'h3333_4444, 32'h0, 1'b0, a);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t32_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("t32_dout", {24'b0, dout_sh0, dout_sh1}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
            if (out_valid) cnt++;
        end
        checkOutput("t32_no_stale", cnt, 32'd0);

        // Random traffic with random backpressure
        accepted = 0; delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                          $urandom_range(0, 2) != 0, a);
        end
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, a);
        checkOutput("t33_drained", q.size(), 32'd0);
        checkOutput("t33_none_lost", delivered, accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prince_sbox_cms_reg.md
PRINCE_SBOX_CMS_REG -- requirements
Module: prince_sbox_cms_reg

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be asynchronous and active-high; ports are listed below.
REQ-002 clk  input  1  sole clock, all flops on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  din_sh carries a complete expanded S-box result.
REQ-005 in_ready  output  1  block accepts din_sh this cycle.
REQ-006 din_sh  input  32  8 CMS output shares x 4 bits from the component functions; share k = bits [4k+3:4k].
REQ-007 rnd  input  32  fresh randomness, sampled only on accept.
REQ-008 out_valid  output  1  dout_sh0/dout_sh1 hold a valid 2-share nibble.
REQ-009 out_ready  input  1  downstream accepts the output this cycle.
REQ-010 dout_sh0  output  4  compressed share 0.
REQ-011 dout_sh1  output  4  compressed share 1.

Function
REQ-012 An accept SHALL occur when in_valid and in_ready are both 1; only then are din_sh and rnd captured into stage-1 registers.
REQ-013 Stage 1 SHALL register all 8 shares unmodified except for the refresh of REQ-021; no XOR across shares before this register.
REQ-014 Stage 2 SHALL register dout_sh0 = XOR of stage-1 shares 0..3 and dout_sh1 = XOR of shares 4..7.
REQ-015 Latency SHALL be 2 cycles, accept to out_valid, with no stalls; throughput SHALL be one nibble per cycle.
REQ-016 in_ready SHALL be 1 when stage 1 is empty or stage 1 can advance; stage 1 advances when stage 2 is empty or out_ready is 1.
REQ-017 While out_valid=1 and out_ready=0, dout_sh0, dout_sh1 and out_valid SHALL hold stable.
REQ-018 Simultaneous output handshake and new accept SHALL move both stages in the same cycle without data loss or duplication.
REQ-019 The unmasked value dout_sh0 ^ dout_sh1 SHALL equal the XOR of all 8 input shares of the corresponding accept.
REQ-020 Ordering SHALL be strict FIFO; the block SHALL never drop or reorder results.

Reset
REQ-021 (see Configuration) ring refresh definition: share k ^= rnd[4k+3:4k] ^ rnd[4((k+1) mod 8)+3 : 4((k+1) mod 8)].
REQ-022 On rst=1: out_valid=0, both stage valid flags=0, dout_sh0=0, dout_sh1=0, all share registers=0, in_ready=1 from the first cycle after release.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight data; no partial result SHALL appear after release.

Configuration
REQ-024 Macro PRINCE_CMS_REFRESH_EN defined: stage-1 capture applies the ring refresh of REQ-021.
REQ-025 Macro undefined: rnd is present but ignored, shares are captured unrefreshed; timing and handshake identical.

Structure
REQ-026 Package prince_cms_pkg SHALL hold NIBBLE_W=4, NUM_OUT_SH=8, NUM_IN_SH=2, and typedef cms_shares_t (array of NUM_OUT_SH nibbles).
REQ-027 Refresh logic SHALL be the single sub-module cms_ring_refresh (combinational, 8x4-bit in, 32-bit rnd, 8x4-bit out).

Verification
REQ-028 Reset release, in_valid=1, din_sh=32'h0000_000F, rnd=0, out_ready=1 -> out_valid=1 two cycles later, dout_sh0=4'hF, dout_sh1=4'h0.
REQ-029 Refresh on, din_sh=32'h1234_5678, rnd=32'hA5A5_5A5A -> dout_sh0^dout_sh1 = 4'h8 (XOR of all nibbles); shares differ from refresh-off run.
REQ-030 Stream 10 back-to-back nibbles, out_ready=1 -> 10 outputs on consecutive cycles, in order, unmasked values correct.
REQ-031 out_ready=0 for 5 cycles with 3 accepts offered -> exactly 2 accepted, in_ready=0 afterwards, output stable; release -> both delivered in order.
REQ-032 rst pulsed while both stages full -> out_valid=0 and outputs 0 immediately; no stale output after release.
REQ-033 Refresh on, random din_sh/rnd 10k cycles, random out_ready -> scoreboard unmasked values match, none lost.
